rv32i_exec_unit: RTL and testbench
==================================

# rv32i_exec_unit

Combinational ID/EX datapath core of the 5-stage RV32I pipeline. It decodes the ID-stage instruction into control bits and an immediate, resolves EX-stage operand hazards by forwarding from MEM/WB, and computes the ALU result. The result serves as the address for loads and stores, and as the taken flag for branches and JAL. It sits between the IF/ID and ID/EX pipeline registers (decode half) and the ID/EX and EX/MEM registers (execute half).

## Interface
- No parameters.
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `instr_raw` in 32: ID-stage instruction.
- `jal`, `branch`, `mem_read`, `mem_write`, `alu_src`, `reg_write` out 1 each: decoded controls.
- `alu_op` out 4: decoded ALU op.
- `imm` out 32: sign-extended immediate.
- `ex_alu_op` in 4, `ex_alu_src` in 1, `ex_imm` in 32: EX-stage controls from the ID/EX register.
- `ex_rs1_addr`, `ex_rs2_addr` in 5; `ex_rs1_val`, `ex_rs2_val` in 32: EX-stage source registers.
- `mem_reg_write` in 1, `mem_rd_addr` in 5, `mem_rd_val` in 32: EX/MEM writeback candidate.
- `wb_rd_addr` in 5, `wb_rd_val` in 32: MEM/WB writeback. Address 0 means no write.
- `rs1`, `rs2` out 32: forwarded operands. `rs2` is also the store data.
- `result` out 32: ALU output.

## Operation
- ALU ops: NONE=0 gives 0; ADD=1; SUB=2; AND=3; OR=4; XOR=5; SLL=6; SRL=7; SRA=8; SLT=9; SLTU=10; EQ=11; NE=12; GE=13 (signed); GEU=14; TRUE=15 gives 1.
- Compare ops return 32'd0 or 32'd1.
- Shifts use src2[4:0].
- Arithmetic is modulo 2^32.
- ALU inputs: src1 = `rs1`; src2 = `ex_alu_src` ? `ex_imm` : `rs2`.
- Forwarding, applied per operand:
  - If `mem_reg_write` && `mem_rd_addr` != 0 && the address matches, take `mem_rd_val`.
  - Else if `wb_rd_addr` != 0 && the address matches, take `wb_rd_val`.
  - Else take `ex_rsN_val`.
  - MEM has priority over WB. x0 is never forwarded.
- Decode by opcode:
  - OP (0110011): ops per funct3/funct7. funct7 0100000 is valid only for SUB and SRA. alu_src=0, reg_write=1, imm=0.
  - OP-IMM (0010011): I-immediate, alu_src=1, reg_write=1. SRLI vs SRAI is selected by instr[30]. There is no SUBI.
  - LOAD (0000011): funct3=010 only. ADD, alu_src=1, mem_read=1, reg_write=1, I-immediate.
  - STORE (0100011): funct3=010 only. ADD, alu_src=1, mem_write=1, S-immediate.
  - BRANCH (1100011): branch=1, alu_src=0, B-immediate. BEQ→EQ, BNE→NE, BLT→SLT, BGE→GE, BLTU→SLTU, BGEU→GEU.
  - JAL (1101111): jal=1, branch=1, reg_write=1, alu_src=1, op TRUE, J-immediate.
- Any other opcode, funct3 or funct7 combination decodes as a bubble: all controls 0, alu_op NONE, imm 0. This covers LUI, AUIPC, JALR and byte/half memory ops.
- reg_write is asserted even when rd=0. Writes to x0 are harmless downstream.

## Timing
- Fully combinational from inputs to outputs, with zero latency.
- `clock` exists only for the reset convention. No internal state.
- While `reset`=1: all decode controls = 0, `alu_op`=NONE, `imm`=0. ID/EX therefore captures bubbles on reset edges.
- `rs1`, `rs2` and `result` are unaffected by reset.
- Load-use hazards are resolved by the pipeline stall, not here. After the stall, the load's data arrives via the WB path.

## Configuration
- `RV32I_FWD_EN`:
  - Defined: forwarding as specified above.
  - Undefined: `rs1`=`ex_rs1_val` and `rs2`=`ex_rs2_val` unconditionally. Software must then insert NOPs between dependent instructions.

## Structure
- Shared package holds: opcode constants; ALU op encodings; NOP constant 32'h00000013; TRUE/FALSE.
- One natural sub-module: `rv32i_alu`, the op, src1, src2 → result datapath.
- Decode and forwarding stay inline.

## Test plan
- ALU: SUB 5−7 gives 0xFFFFFFFE. SRA 0x80000000 by 4 gives 0xF8000000. SRL of the same gives 0x08000000. SLTU 1 vs 0xFFFFFFFF gives 1.
- Decode `sw x6,8(x2)` (0x00612423): mem_write=1, alu_src=1, ADD, imm=8, reg_write=0.
- Decode `beq x5,x6,-8` (0xFE628CE3): branch=1, EQ, imm=0xFFFFFFF8. With rs1=rs2=3 the result is 1.
- Decode `jal x1,16` (0x010000EF): jal=1, branch=1, reg_write=1, op TRUE, imm=16, result=1.
- Forwarding with rs1=5, mem rd=5/val 0xAA/write=1, wb rd=5/val 0xBB: rs1=0xAA. With mem_reg_write=0: rs1=0xBB. With rs1 addr 0 and both paths targeting 0: rs1=ex_rs1_val.
- Assert reset while instr=0x00000033 (ADD): all controls 0 and alu_op=0. Deassert: reg_write=1, ADD.

Source files
------------

// File: rtl/rv32i_exec_unit_pkg.sv
// ============================================================================
// Module : rv32i_exec_unit_pkg
// Brief  : Shared opcodes, ALU op encodings and decoded-control type for the
//          RV32I ID/EX datapath core.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_exec_unit_pkg;

    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;

    localparam logic [6:0] c_f7_base    = 7'b0000000;
    localparam logic [6:0] c_f7_alt     = 7'b0100000;

    localparam logic [31:0] c_nop   = 32'h0000_0013;
    localparam logic [31:0] c_true  = 32'd1;
    localparam logic [31:0] c_false = 32'd0;

    typedef enum logic [3:0] {
        ALU_NONE = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10,
        ALU_EQ   = 4'd11,
        ALU_NE   = 4'd12,
        ALU_GE   = 4'd13,
        ALU_GEU  = 4'd14,
        ALU_TRUE = 4'd15
    } alu_op_e;

    typedef struct packed {
        logic        jal;
        logic        branch;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src;
        logic        reg_write;
        alu_op_e     alu_op;
        logic [31:0] imm;
    } ctrl_t;

    localparam ctrl_t c_bubble = '{
        jal: 1'b0, branch: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
        alu_src: 1'b0, reg_write: 1'b0, alu_op: ALU_NONE, imm: 32'd0
    };

    // Register-register op for funct3 with the base funct7; also the OP-IMM table.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32i_exec_unit_if.sv
// ============================================================================
// Module : rv32i_exec_unit_if
// Brief  : Decode, EX-operand and writeback-forwarding signals of the
//          RV32I ID/EX datapath core, grouped with master/slave views.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rv32i_exec_unit_if;

    logic [31:0] instr_raw;
    logic        jal;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic        reg_write;
    logic [3:0]  alu_op;
    logic [31:0] imm;

    logic [3:0]  ex_alu_op;
    logic        ex_alu_src;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs1_addr;
    logic [4:0]  ex_rs2_addr;
    logic [31:0] ex_rs1_val;
    logic [31:0] ex_rs2_val;

    logic        mem_reg_write;
    logic [4:0]  mem_rd_addr;
    logic [31:0] mem_rd_val;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_val;

    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] result;

    modport master (
        output instr_raw,
        input  jal, branch, mem_read, mem_write, alu_src, reg_write, alu_op, imm,
        output ex_alu_op, ex_alu_src, ex_imm,
        output ex_rs1_addr, ex_rs2_addr, ex_rs1_val, ex_rs2_val,
        output mem_reg_write, mem_rd_addr, mem_rd_val, wb_rd_addr, wb_rd_val,
        input  rs1, rs2, result
    );

    modport slave (
        input  instr_raw,
        output jal, branch, mem_read, mem_write, alu_src, reg_write, alu_op, imm,
        input  ex_alu_op, ex_alu_src, ex_imm,
        input  ex_rs1_addr, ex_rs2_addr, ex_rs1_val, ex_rs2_val,
        input  mem_reg_write, mem_rd_addr, mem_rd_val, wb_rd_addr, wb_rd_val,
        output rs1, rs2, result
    );

endinterface

`default_nettype wire

// File: rtl/rv32i_exec_unit_alu.sv
// ============================================================================
// Module : rv32i_alu
// Brief  : Combinational RV32I ALU; compares return 0/1, shifts use src2[4:0].
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_alu
    import rv32i_exec_unit_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_src1,
    input  logic [31:0] i_src2,
    output logic [31:0] o_result
);

    logic [4:0] w_shamt;
    assign w_shamt = i_src2[4:0];

    always_comb begin
        o_result = c_false;
        case (i_op)
            ALU_ADD:  o_result = i_src1 + i_src2;
            ALU_SUB:  o_result = i_src1 - i_src2;
            ALU_AND:  o_result = i_src1 & i_src2;
            ALU_OR:   o_result = i_src1 | i_src2;
            ALU_XOR:  o_result = i_src1 ^ i_src2;
            ALU_SLL:  o_result = i_src1 << w_shamt;
            ALU_SRL:  o_result = i_src1 >> w_shamt;
            ALU_SRA:  o_result = $unsigned($signed(i_src1) >>> w_shamt);
            ALU_SLT:  o_result = ($signed(i_src1) <  $signed(i_src2)) ? c_true : c_false;
            ALU_SLTU: o_result = (i_src1 <  i_src2) ? c_true : c_false;
            ALU_EQ:   o_result = (i_src1 == i_src2) ? c_true : c_false;
            ALU_NE:   o_result = (i_src1 != i_src2) ? c_true : c_false;
            ALU_GE:   o_result = ($signed(i_src1) >= $signed(i_src2)) ? c_true : c_false;
            ALU_GEU:  o_result = (i_src1 >= i_src2) ? c_true : c_false;
            ALU_TRUE: o_result = c_true;
            default:  o_result = c_false;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rv32i_exec_unit.sv
// ============================================================================
// Module : rv32i_exec_unit
// Brief  : Combinational ID/EX core: instruction decode, MEM/WB operand
//          forwarding (enabled by `RV32I_FWD_EN`) and the ALU.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_exec_unit
    import rv32i_exec_unit_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    rv32i_exec_unit_if.slave  bus
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;
    ctrl_t       w_ctrl;
    alu_op_e     w_op;

    assign w_opcode = bus.instr_raw[6:0];
    assign w_f3     = bus.instr_raw[14:12];
    assign w_f7     = bus.instr_raw[31:25];

    assign w_imm_i = {{20{bus.instr_raw[31]}}, bus.instr_raw[31:20]};
    assign w_imm_s = {{20{bus.instr_raw[31]}}, bus.instr_raw[31:25], bus.instr_raw[11:7]};
    assign w_imm_b = {{19{bus.instr_raw[31]}}, bus.instr_raw[31], bus.instr_raw[7],
                      bus.instr_raw[30:25], bus.instr_raw[11:8], 1'b0};
    assign w_imm_j = {{11{bus.instr_raw[31]}}, bus.instr_raw[31], bus.instr_raw[19:12],
                      bus.instr_raw[20], bus.instr_raw[30:21], 1'b0};

    // Anything not explicitly recognised stays a bubble; reset forces a bubble too.
    always_comb begin
        w_ctrl = c_bubble;
        w_op   = ALU_NONE;
        if (!reset) begin
            case (w_opcode)
                c_opc_op: begin
                    if (w_f7 == c_f7_base)
                        w_op = alu_from_f3(w_f3);
                    else if (w_f7 == c_f7_alt && w_f3 == 3'b000)
                        w_op = ALU_SUB;
                    else if (w_f7 == c_f7_alt && w_f3 == 3'b101)
                        w_op = ALU_SRA;
                    if (w_op != ALU_NONE) begin
                        w_ctrl.reg_write = 1'b1;
                        w_ctrl.alu_op    = w_op;
                    end
                end
                c_opc_op_imm: begin
                    if (w_f3 == 3'b001)
                        w_op = (w_f7 == c_f7_base) ? ALU_SLL : ALU_NONE;
                    else if (w_f3 == 3'b101)
                        w_op = (w_f7 == c_f7_base) ? ALU_SRL :
                               (w_f7 == c_f7_alt)  ? ALU_SRA : ALU_NONE;
                    else
                        w_op = alu_from_f3(w_f3);
                    if (w_op != ALU_NONE) begin
                        w_ctrl.alu_src   = 1'b1;
                        w_ctrl.reg_write = 1'b1;
                        w_ctrl.alu_op    = w_op;
                        w_ctrl.imm       = w_imm_i;
                    end
                end
                c_opc_load: begin
                    if (w_f3 == 3'b010) begin
                        w_ctrl.mem_read  = 1'b1;
                        w_ctrl.alu_src   = 1'b1;
                        w_ctrl.reg_write = 1'b1;
                        w_ctrl.alu_op    = ALU_ADD;
                        w_ctrl.imm       = w_imm_i;
                    end
                end
                c_opc_store: begin
                    if (w_f3 == 3'b010) begin
                        w_ctrl.mem_write = 1'b1;
                        w_ctrl.alu_src   = 1'b1;
                        w_ctrl.alu_op    = ALU_ADD;
                        w_ctrl.imm       = w_imm_s;
                    end
                end
                c_opc_branch: begin
                    case (w_f3)
                        3'b000:  w_op = ALU_EQ;
                        3'b001:  w_op = ALU_NE;
                        3'b100:  w_op = ALU_SLT;
                        3'b101:  w_op = ALU_GE;
                        3'b110:  w_op = ALU_SLTU;
                        3'b111:  w_op = ALU_GEU;
                        default: w_op = ALU_NONE;
                    endcase
                    if (w_op != ALU_NONE) begin
                        w_ctrl.branch = 1'b1;
                        w_ctrl.alu_op = w_op;
                        w_ctrl.imm    = w_imm_b;
                    end
                end
                c_opc_jal: begin
                    w_ctrl.jal       = 1'b1;
                    w_ctrl.branch    = 1'b1;
                    w_ctrl.reg_write = 1'b1;
                    w_ctrl.alu_src   = 1'b1;
                    w_ctrl.alu_op    = ALU_TRUE;
                    w_ctrl.imm       = w_imm_j;
                end
                default: w_ctrl = c_bubble;
            endcase
        end
    end

    assign bus.jal       = w_ctrl.jal;
    assign bus.branch    = w_ctrl.branch;
    assign bus.mem_read  = w_ctrl.mem_read;
    assign bus.mem_write = w_ctrl.mem_write;
    assign bus.alu_src   = w_ctrl.alu_src;
    assign bus.reg_write = w_ctrl.reg_write;
    assign bus.alu_op    = w_ctrl.alu_op;
    assign bus.imm       = w_ctrl.imm;

    logic [31:0] w_rs1;
    logic [31:0] w_rs2;
    logic        w_unused_clock;

    // No state here: the clock is carried only for the pipeline's reset convention.
    assign w_unused_clock = clock;

`ifdef RV32I_FWD_EN
    // MEM beats WB; x0 is never a forwarding target.
    always_comb begin
        w_rs1 = bus.ex_rs1_val;
        if (bus.mem_reg_write && bus.mem_rd_addr != 5'd0 && bus.mem_rd_addr == bus.ex_rs1_addr)
            w_rs1 = bus.mem_rd_val;
        else if (bus.wb_rd_addr != 5'd0 && bus.wb_rd_addr == bus.ex_rs1_addr)
            w_rs1 = bus.wb_rd_val;

        w_rs2 = bus.ex_rs2_val;
        if (bus.mem_reg_write && bus.mem_rd_addr != 5'd0 && bus.mem_rd_addr == bus.ex_rs2_addr)
            w_rs2 = bus.mem_rd_val;
        else if (bus.wb_rd_addr != 5'd0 && bus.wb_rd_addr == bus.ex_rs2_addr)
            w_rs2 = bus.wb_rd_val;
    end
`else
    logic w_unused_fwd;

    assign w_rs1 = bus.ex_rs1_val;
    assign w_rs2 = bus.ex_rs2_val;
    assign w_unused_fwd = ^{bus.ex_rs1_addr, bus.ex_rs2_addr, bus.mem_reg_write,
                            bus.mem_rd_addr, bus.mem_rd_val, bus.wb_rd_addr, bus.wb_rd_val};
`endif

    assign bus.rs1 = w_rs1;
    assign bus.rs2 = w_rs2;

    logic [31:0] w_src2;
    assign w_src2 = bus.ex_alu_src ? bus.ex_imm : w_rs2;

    rv32i_alu u_alu (
        .i_op     (bus.ex_alu_op),
        .i_src1   (w_rs1),
        .i_src2   (w_src2),
        .o_result (bus.result)
    );

endmodule

`default_nettype wire

// File: tb/tb_rv32i_exec_unit.sv
// ============================================================================
// Module : tb_rv32i_exec_unit
// Brief  : Directed and randomized checks of rv32i_exec_unit against an
//          instruction-encoder / arithmetic reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32i_exec_unit;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    rv32i_exec_unit_if bus ();

    rv32i_exec_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [9:0] dut_ctrl;
    assign dut_ctrl = {bus.jal, bus.branch, bus.mem_read, bus.mem_write,
                       bus.alu_src, bus.reg_write, bus.alu_op};

    int base_tbl [8] = '{1, 6, 9, 10, 5, 7, 4, 3};
    int br_tbl   [8] = '{11, 12, 0, 0, 9, 13, 10, 14};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        longint      sa;
        sh = b % 32;
        sa = longint'(int'(a));
        case (op)
            1:  return a + b;
            2:  return a - b;
            3:  return a & b;
            4:  return a | b;
            5:  return a ^ b;
            6:  return a << sh;
            7:  return a >> sh;
            8:  return 32'(sa >>> sh);
            9:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            10: return (a < b) ? 32'd1 : 32'd0;
            11: return (a == b) ? 32'd1 : 32'd0;
            12: return (a != b) ? 32'd1 : 32'd0;
            13: return (int'(a) >= int'(b)) ? 32'd1 : 32'd0;
            14: return (a >= b) ? 32'd1 : 32'd0;
            15: return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] addr, input logic [31:0] val,
                                            input logic mw, input logic [4:0] md, input logic [31:0] mv,
                                            input logic [4:0] wd, input logic [31:0] wv);
`ifdef RV32I_FWD_EN
        if (mw && md != 0 && md == addr) return mv;
        if (wd != 0 && wd == addr) return wv;
`endif
        return val;
    endfunction

    // Builds a random instruction from fields and returns what decode should yield.
    task automatic gen_instr(output logic [31:0] ins, output logic [9:0] ec, output logic [31:0] ei);
        int          kind;
        int          op;
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] iv;
        logic [24:0] upper;
        logic [6:0]  opcs [3];
        opcs  = '{7'b0110111, 7'b0010111, 7'b1100111};
        kind  = $urandom_range(0, 6);
        rd    = 5'($urandom);
        r1    = 5'($urandom);
        r2    = 5'($urandom);
        f3    = 3'($urandom);
        iv    = $urandom_range(0, 4095) - 2048;
        ec    = '0;
        ei    = '0;
        case (kind)
            0: begin
                f7 = ($urandom_range(0, 3) == 0) ? 7'h20 :
                     ($urandom_range(0, 5) == 0) ? 7'($urandom) : 7'h00;
                ins = {f7, r2, r1, f3, rd, 7'b0110011};
                op = 0;
                if (f7 == 7'h00) op = base_tbl[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) op = 2;
                else if (f7 == 7'h20 && f3 == 3'd5) op = 8;
                if (op != 0) ec = {6'b000001, 4'(op)};
            end
            1: begin
                if (f3 == 3'd1) begin
                    iv = $urandom_range(0, 31);
                    op = 6;
                end else if (f3 == 3'd5) begin
                    op = ($urandom_range(0, 1) == 1) ? 8 : 7;
                    iv = $urandom_range(0, 31) + ((op == 8) ? 1024 : 0);
                end else begin
                    op = base_tbl[f3];
                end
                ins = {iv[11:0], r1, f3, rd, 7'b0010011};
                ec  = {6'b000011, 4'(op)};
                ei  = iv;
            end
            2: begin
                if ($urandom_range(0, 2) != 0) f3 = 3'd2;
                ins = {iv[11:0], r1, f3, rd, 7'b0000011};
                if (f3 == 3'd2) begin ec = {6'b001011, 4'd1}; ei = iv; end
            end
            3: begin
                if ($urandom_range(0, 2) != 0) f3 = 3'd2;
                ins = {iv[11:5], r2, r1, f3, iv[4:0], 7'b0100011};
                if (f3 == 3'd2) begin ec = {6'b000110, 4'd1}; ei = iv; end
            end
            4: begin
                iv  = ($urandom_range(0, 4095) - 2048) * 2;
                ins = {iv[12], iv[10:5], r2, r1, f3, iv[4:1], iv[11], 7'b1100011};
                op  = br_tbl[f3];
                if (op != 0) begin ec = {6'b010000, 4'(op)}; ei = iv; end
            end
            5: begin
                iv  = ($urandom_range(0, (1 << 20) - 1) - (1 << 19)) * 2;
                ins = {iv[20], iv[10:1], iv[11], iv[19:12], rd, 7'b1101111};
                ec  = {6'b110011, 4'd15};
                ei  = iv;
            end
            default: begin
                upper = 25'($urandom);
                ins   = {upper, opcs[$urandom_range(0, 2)]};
            end
        endcase
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] ins, ei, e1, e2, es2;
        logic [9:0]  ec;
        int          op;

        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.instr_raw     = 32'h0000_0033;
        bus.ex_alu_op     = 4'd0;
        bus.ex_alu_src    = 1'b0;
        bus.ex_imm        = 32'd0;
        bus.ex_rs1_addr   = 5'd1;
        bus.ex_rs2_addr   = 5'd2;
        bus.ex_rs1_val    = 32'd0;
        bus.ex_rs2_val    = 32'd0;
        bus.mem_reg_write = 1'b0;
        bus.mem_rd_addr   = 5'd0;
        bus.mem_rd_val    = 32'd0;
        bus.wb_rd_addr    = 5'd0;
        bus.wb_rd_val     = 32'd0;

        @(negedge clock);
        check("reset_ctrl", 32'(dut_ctrl), 32'd0);
        check("reset_imm", bus.imm, 32'd0);
        step();
        bus.instr_raw = 32'h0100_00EF;
        @(negedge clock);
        check("reset_jal_ctrl", 32'(dut_ctrl), 32'd0);
        step();
        reset = 1'b0;
        bus.instr_raw = 32'h0000_0033;
        @(negedge clock);
        check("post_reset_add", 32'(dut_ctrl), 32'(10'b0000010001));

        // Directed ALU cases with no forwarding paths active.
        step();
        bus.ex_alu_op = 4'd2; bus.ex_rs1_val = 32'd5; bus.ex_rs2_val = 32'd7;
        @(negedge clock);
        check("alu_sub", bus.result, 32'hFFFF_FFFE);
        step();
        bus.ex_alu_op = 4'd8; bus.ex_rs1_val = 32'h8000_0000; bus.ex_rs2_val = 32'd4;
        @(negedge clock);
        check("alu_sra", bus.result, 32'hF800_0000);
        step();
        bus.ex_alu_op = 4'd7;
        @(negedge clock);
        check("alu_srl", bus.result, 32'h0800_0000);
        step();
        bus.ex_alu_op = 4'd10; bus.ex_rs1_val = 32'd1; bus.ex_rs2_val = 32'hFFFF_FFFF;
        @(negedge clock);
        check("alu_sltu", bus.result, 32'd1);

        step();
        bus.instr_raw = 32'h0061_2423;
        @(negedge clock);
        check("sw_ctrl", 32'(dut_ctrl), 32'(10'b0001100001));
        check("sw_imm", bus.imm, 32'd8);
        step();
        bus.instr_raw = 32'hFE62_8CE3;
        bus.ex_alu_op = 4'd11; bus.ex_alu_src = 1'b0; bus.ex_imm = 32'hFFFF_FFF8;
        bus.ex_rs1_val = 32'd3; bus.ex_rs2_val = 32'd3;
        @(negedge clock);
        check("beq_ctrl", 32'(dut_ctrl), 32'(10'b0100001011));
        check("beq_imm", bus.imm, 32'hFFFF_FFF8);
        check("beq_result", bus.result, 32'd1);
        step();
        bus.instr_raw = 32'h0100_00EF;
        bus.ex_alu_op = 4'd15; bus.ex_alu_src = 1'b1; bus.ex_imm = 32'd16;
        @(negedge clock);
        check("jal_ctrl", 32'(dut_ctrl), 32'(10'b1100111111));
        check("jal_imm", bus.imm, 32'd16);
        check("jal_result", bus.result, 32'd1);

        // Forwarding priority and x0 exclusion.
        step();
        bus.ex_rs1_addr = 5'd5; bus.ex_rs1_val = 32'h11;
        bus.mem_reg_write = 1'b1; bus.mem_rd_addr = 5'd5; bus.mem_rd_val = 32'hAA;
        bus.wb_rd_addr = 5'd5; bus.wb_rd_val = 32'hBB;
        @(negedge clock);
`ifdef RV32I_FWD_EN
        check("fwd_mem", bus.rs1, 32'hAA);
`else
        check("fwd_mem", bus.rs1, 32'h11);
`endif
        step();
        bus.mem_reg_write = 1'b0;
        @(negedge clock);
`ifdef RV32I_FWD_EN
        check("fwd_wb", bus.rs1, 32'hBB);
`else
        check("fwd_wb", bus.rs1, 32'h11);
`endif
        step();
        bus.mem_reg_write = 1'b1; bus.ex_rs1_addr = 5'd0;
        bus.mem_rd_addr = 5'd0; bus.wb_rd_addr = 5'd0;
        @(negedge clock);
        check("fwd_x0", bus.rs1, 32'h11);

        // Randomized decode against the encoder model.
        for (int i = 0; i < 200; i++) begin
            step();
            gen_instr(ins, ec, ei);
            bus.instr_raw = ins;
            @(negedge clock);
            check($sformatf("rand_ctrl[%h]", ins), 32'(dut_ctrl), 32'(ec));
            check($sformatf("rand_imm[%h]", ins), bus.imm, ei);
        end

        // Randomized datapath with small register indices to provoke forwarding.
        for (int i = 0; i < 200; i++) begin
            step();
            op = $urandom_range(0, 15);
            bus.ex_alu_op     = 4'(op);
            bus.ex_alu_src    = 1'($urandom);
            bus.ex_imm        = $urandom;
            bus.ex_rs1_addr   = 5'($urandom_range(0, 3));
            bus.ex_rs2_addr   = 5'($urandom_range(0, 3));
            bus.ex_rs1_val    = $urandom;
            bus.ex_rs2_val    = ($urandom_range(0, 3) == 0) ? bus.ex_rs1_val : $urandom;
            bus.mem_reg_write = 1'($urandom);
            bus.mem_rd_addr   = 5'($urandom_range(0, 3));
            bus.mem_rd_val    = $urandom;
            bus.wb_rd_addr    = 5'($urandom_range(0, 3));
            bus.wb_rd_val     = $urandom;
            e1  = ref_fwd(bus.ex_rs1_addr, bus.ex_rs1_val, bus.mem_reg_write,
                          bus.mem_rd_addr, bus.mem_rd_val, bus.wb_rd_addr, bus.wb_rd_val);
            e2  = ref_fwd(bus.ex_rs2_addr, bus.ex_rs2_val, bus.mem_reg_write,
                          bus.mem_rd_addr, bus.mem_rd_val, bus.wb_rd_addr, bus.wb_rd_val);
            es2 = bus.ex_alu_src ? bus.ex_imm : e2;
            @(negedge clock);
            check($sformatf("rand_rs1[%0d]", i), bus.rs1, e1);
            check($sformatf("rand_rs2[%0d]", i), bus.rs2, e2);
            check($sformatf("rand_result[op%0d]", op), bus.result, ref_alu(op, e1, es2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
